// File: rtl/pong_if.sv
// ============================================================================
// pong_if : ball shift register / move timer / win detector control bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface pong_if;
  logic [17:0] Q;
  logic        DIR;
  logic        TC;
  logic        GAMEOVER;
  logic        LOAD;
  logic        SHL;
  logic        SHR;
  logic        SET;
  logic        MAX;

  modport master (
    input  Q, DIR, TC, GAMEOVER,
    output LOAD, SHL, SHR, SET, MAX
  );

  modport slave (
    output Q, DIR, TC, GAMEOVER,
    input  LOAD, SHL, SHR, SET, MAX
  );
endinterface

`default_nettype wire

// File: rtl/pong_ctrl.sv
// ============================================================================
// pong_ctrl : Pong game sequencer - serve, ball motion, hits, BCD scoring
// Rev 1.0
// ============================================================================
`default_nettype none

module pong_ctrl #(
  parameter logic [7:0] WIN_SCORE = 8'h12
) (
  input  wire logic       CLK,
  input  wire logic       CLRN,
  input  wire logic       BTN1,
  input  wire logic       BTN0,
  pong_if.master          bus,
  output logic      [7:0] SCORE1,
  output logic      [7:0] SCORE0,
  output logic            WINNER,
  output logic      [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_MOVE_L = 3'd2,
    S_MOVE_R = 3'd3,
    S_POINT  = 3'd4,
    S_CHECK  = 3'd5,
    S_OVER   = 3'd6
  } state_t;

  state_t     r_state;
  logic [2:0] r_b1;
  logic [2:0] r_b0;
  logic       r_hit1;
  logic       r_hit0;
  logic       r_dir;
  logic       r_scorer;
  logic       r_load;
  logic       r_shl;
  logic       r_shr;
  logic       r_set;
  logic       r_max;
  logic [7:0] r_score1;
  logic [7:0] r_score0;
  logic       r_winner;

  // r_bx[1:0] is the 2-flop synchronizer, r_bx[2] the edge-detect history
  wire logic w_rise1 = r_b1[1] & ~r_b1[2];
  wire logic w_rise0 = r_b0[1] & ~r_b0[2];

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)
      return s;
    if (s[3:0] >= 4'h9)
      return {s[7:4] + 4'h1, 4'h0};
    return {s[7:4], s[3:0] + 4'h1};
  endfunction

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      r_state  <= S_IDLE;
      r_b1     <= 3'b000;
      r_b0     <= 3'b000;
      r_hit1   <= 1'b0;
      r_hit0   <= 1'b0;
      r_dir    <= 1'b0;
      r_scorer <= 1'b0;
      r_load   <= 1'b0;
      r_shl    <= 1'b0;
      r_shr    <= 1'b0;
      r_set    <= 1'b0;
      r_max    <= 1'b0;
      r_score1 <= 8'h00;
      r_score0 <= 8'h00;
      r_winner <= 1'b0;
    end else begin
      r_b1   <= {r_b1[1:0], BTN1};
      r_b0   <= {r_b0[1:0], BTN0};
      r_hit1 <= w_rise1;
      r_hit0 <= w_rise0;
      r_load <= 1'b0;
      r_shl  <= 1'b0;
      r_shr  <= 1'b0;
      r_set  <= 1'b0;
      r_max  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (r_hit1 || r_hit0) begin
            r_dir   <= bus.DIR;
            r_load  <= 1'b1;
            r_max   <= 1'b1;
            r_state <= S_SERVE;
          end
        end
        S_SERVE: begin
          r_state <= r_dir ? S_MOVE_L : S_MOVE_R;
        end
        S_MOVE_L: begin
          // A hit at the end position takes priority over a same-cycle TC
          if (r_hit1 && bus.Q[17]) begin
            r_set   <= 1'b1;
            r_state <= S_MOVE_R;
          end else if (bus.TC) begin
            r_shl <= 1'b1;
            if (bus.Q[17]) begin
              r_scorer <= 1'b0;
              r_state  <= S_POINT;
            end
          end
        end
        S_MOVE_R: begin
          if (r_hit0 && bus.Q[0]) begin
            r_set   <= 1'b1;
            r_state <= S_MOVE_L;
          end else if (bus.TC) begin
            r_shr <= 1'b1;
            if (bus.Q[0]) begin
              r_scorer <= 1'b1;
              r_state  <= S_POINT;
            end
          end
        end
        S_POINT: begin
          if (r_scorer)
            r_score1 <= bcd_inc(r_score1);
          else
            r_score0 <= bcd_inc(r_score0);
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (bus.GAMEOVER) begin
            r_winner <= r_scorer;
            r_state  <= S_OVER;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_OVER;
        end
      endcase
    end
  end

  assign bus.LOAD = r_load;
  assign bus.SHL  = r_shl;
  assign bus.SHR  = r_shr;
  assign bus.SET  = r_set;
  assign bus.MAX  = r_max;
  assign SCORE1   = r_score1;
  assign SCORE0   = r_score0;
  assign WINNER   = r_winner;
  assign STATE    = r_state;

endmodule

`default_nettype wire

// File: doc/pong_ctrl.md
# pong_ctrl

Game sequencer for the Pong datapath. Watches the 18-bit ball shift register, the variable-period move timer and the two player buttons. Drives the shift register's LOAD/SHL/SHR and the timer's SET/MAX, and keeps both players' BCD scores, which feed the win detector. Sits between the button inputs and the shift_reg / var_timer / win_det instances at game top level.

## Interface
Parameters:
- WIN_SCORE, 8'h12, BCD score at which the game ends; must match the win detector threshold.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- CLRN  in  1  asynchronous active-low reset.
- Q  in  18  ball shift register contents; Q[17] is player 1's end, Q[0] is player 0's end.
- DIR  in  1  random serve direction from shift register; 1 = toward player 1 (SHL).
- TC  in  1  move-timer terminal count, single-cycle pulse.
- GAMEOVER  in  1  win detector output.
- BTN1, BTN0  in  1  raw asynchronous player buttons, active high.
- LOAD  out  1  load serve pattern into shift register (1-cycle pulse).
- SHL, SHR  out  1  shift ball toward player 1 / player 0 (1-cycle pulses, never both).
- SET  out  1  speed up move timer (1-cycle pulse on hit).
- MAX  out  1  reset move timer to slowest period (1-cycle pulse on serve).
- SCORE1, SCORE0  out  8  BCD scores.
- WINNER  out  1  1 = player 1 won; valid in OVER.
- STATE  out  3  current state encoding, for debug LEDs.

## Operation
- Buttons: each passes through a 2-flop synchronizer, then a rising-edge detector. This produces a 1-cycle pulse HIT1/HIT0. A held button gives exactly one pulse.
- States (STATE encoding): IDLE=0, SERVE=1, MOVE_L=2, MOVE_R=3, POINT=4, CHECK=5, OVER=6.
- IDLE: entered from reset and after each point.
  - HIT1 or HIT0 → SERVE. Simultaneous pulses count as one serve.
- SERVE (1 cycle): assert LOAD and MAX together. Latch DIR.
  - DIR=1 → MOVE_L; DIR=0 → MOVE_R.
- MOVE_L (ball travelling toward Q[17]):
  - HIT1 while Q[17]=1: assert SET, go to MOVE_R. No shift this TC period.
  - TC while Q[17]=0: assert SHL.
  - TC while Q[17]=1 and no HIT1 in the same cycle: player 1 missed. Assert SHL (ball leaves the display), set pending scorer to player 0, go to POINT.
  - HIT1 while Q[17]=0 is ignored. HIT0 is always ignored.
- MOVE_R: mirror of MOVE_L using Q[0], HIT0 and SHR; a miss scores for player 1.
- Same-cycle HIT and TC at the end position: the hit wins (reverse direction, SET, no shift, no point).
- POINT (1 cycle): BCD-increment the pending scorer's score, then go to CHECK.
  - Low nibble 9 → 0 with carry into the high nibble.
  - 8'h99 saturates at 8'h99.
- CHECK (1 cycle, lets the win detector see the updated score):
  - GAMEOVER=1 → OVER, with WINNER = the scorer.
  - Otherwise → IDLE.
- OVER: all control pulses held at 0 and scores frozen. Only CLRN leaves OVER.
- Reset values: state IDLE, all pulse outputs 0, SCORE1 = SCORE0 = 8'h00, WINNER 0, STATE 0, synchronizers and edge detectors 0, latched direction 0.

## Timing
- All outputs are registered.
- A pulse decided from inputs in cycle n is high during cycle n+1 only. The shift register and timer therefore update at the end of cycle n+1.
- Button latency: BTN rising before edge k produces HIT during cycle k+2, and the response output (SET, or the serve LOAD) is high in cycle k+3.
- SERVE: LOAD and MAX are high in the same single cycle, the cycle after the state enters SERVE.
- At most one of LOAD, SHL, SHR is high in any cycle.
- SET is never high in the same cycle as SHL or SHR.
- Score registers update on the clock edge that leaves POINT. GAMEOVER is sampled in CHECK, one cycle later.
- CLRN low at any time, including mid-shift or in POINT, forces reset values immediately (asynchronous). No partial score update survives.

## Test plan
- Reset, then pulse BTN0 for 3 cycles with DIR=1: exactly one LOAD+MAX pulse, STATE goes 0→1→2, SCORE1 = SCORE0 = 8'h00.
- In MOVE_L, pulse TC with Q=18'h00080: one SHL pulse in the next cycle, no SET, state stays MOVE_L.
- In MOVE_L with Q=18'h20000, assert HIT1 and TC in the same cycle: SET pulses, no SHL, state becomes MOVE_R, scores unchanged.
- In MOVE_R with Q=18'h00001, TC with no BTN0: SHR pulses, then POINT, then CHECK; SCORE1 goes 8'h00→8'h01; state returns to IDLE.
- Preload SCORE1=8'h09, player 1 scores: SCORE1=8'h10. Preload 8'h11, score again with GAMEOVER driven high in CHECK: state OVER, WINNER=1, further button presses and TC produce no outputs.
- Drop CLRN while in POINT: scores 8'h00, state IDLE, all pulses 0 in the same cycle.
